// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : multi-cycle MIPS control FSM with Moore output decode
// Rev 1.0
// ============================================================================
module multicycle_control #(
  parameter bit ENABLE_ADDI  = 1'b1,
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_control,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [3:0] c_ST_FETCH  = 4'd0;
  localparam logic [3:0] c_ST_DECODE = 4'd1;
  localparam logic [3:0] c_ST_MEMADR = 4'd2;
  localparam logic [3:0] c_ST_MEMRD  = 4'd3;
  localparam logic [3:0] c_ST_MEMWB  = 4'd4;
  localparam logic [3:0] c_ST_MEMWR  = 4'd5;
  localparam logic [3:0] c_ST_EXEC   = 4'd6;
  localparam logic [3:0] c_ST_ALUWB  = 4'd7;
  localparam logic [3:0] c_ST_BRANCH = 4'd8;
  localparam logic [3:0] c_ST_ADDIEX = 4'd9;
  localparam logic [3:0] c_ST_ADDIWB = 4'd10;
  localparam logic [3:0] c_ST_JUMP   = 4'd11;
  localparam logic [3:0] c_ST_RESET  = 4'd15;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_MIN = 4'b0111;
  localparam logic [3:0] c_ALU_NOR = 4'b1100;

  localparam int              c_CW       = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [c_CW-1:0] c_WAIT_MAX = c_CW'(MEM_WAIT_MAX);

  logic [3:0]      r_state;
  logic [3:0]      w_next_state;
  logic [c_CW-1:0] r_wait_cnt;
  logic            w_op_legal;
  logic            w_funct_legal;
  logic [3:0]      w_funct_alu;
  logic            w_in_mem;
  logic            w_timeout;

  assign state = r_state;

  always_comb begin
    w_op_legal = 1'b1;
    case (opcode)
      c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J: w_op_legal = 1'b1;
      c_OP_ADDI: w_op_legal = ENABLE_ADDI;
      default:   w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_funct_legal = 1'b1;
    w_funct_alu   = c_ALU_ADD;
    case (funct)
      6'b100000: w_funct_alu = c_ALU_ADD;
      6'b100010: w_funct_alu = c_ALU_SUB;
      6'b100100: w_funct_alu = c_ALU_AND;
      6'b100101: w_funct_alu = c_ALU_OR;
      6'b100111: w_funct_alu = c_ALU_NOR;
      6'b101010: w_funct_alu = c_ALU_MIN;
      default:   w_funct_legal = 1'b0;
    endcase
  end

  // The timeout fires on the cycle after MEM_WAIT_MAX waits, only if memory is still not ready.
  assign w_in_mem  = (r_state == c_ST_FETCH) || (r_state == c_ST_MEMRD) || (r_state == c_ST_MEMWR);
  assign w_timeout = (MEM_WAIT_MAX > 0) && w_in_mem && !mem_ready && (r_wait_cnt == c_WAIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if ((w_next_state != r_state) || w_timeout) begin
      r_wait_cnt <= '0;
    end else if ((MEM_WAIT_MAX > 0) && w_in_mem && !mem_ready) begin
      r_wait_cnt <= r_wait_cnt + c_CW'(1);
    end
  end

  always_comb begin
    w_next_state = c_ST_FETCH;
    case (r_state)
      c_ST_RESET: w_next_state = c_ST_FETCH;
      c_ST_FETCH: begin
        if (mem_ready) begin
          w_next_state = c_ST_DECODE;
        end else begin
          w_next_state = c_ST_FETCH;
        end
      end
      c_ST_DECODE: begin
        case (opcode)
          c_OP_RTYPE:       w_next_state = c_ST_EXEC;
          c_OP_LW, c_OP_SW: w_next_state = c_ST_MEMADR;
          c_OP_BEQ:         w_next_state = c_ST_BRANCH;
          c_OP_J:           w_next_state = c_ST_JUMP;
          c_OP_ADDI:        w_next_state = ENABLE_ADDI ? c_ST_ADDIEX : c_ST_FETCH;
          default:          w_next_state = c_ST_FETCH;
        endcase
      end
      c_ST_MEMADR: begin
        if (opcode == c_OP_LW) begin
          w_next_state = c_ST_MEMRD;
        end else if (opcode == c_OP_SW) begin
          w_next_state = c_ST_MEMWR;
        end else begin
          w_next_state = c_ST_FETCH;
        end
      end
      c_ST_MEMRD: begin
        if (mem_ready) begin
          w_next_state = c_ST_MEMWB;
        end else if (w_timeout) begin
          w_next_state = c_ST_FETCH;
        end else begin
          w_next_state = c_ST_MEMRD;
        end
      end
      c_ST_MEMWR: begin
        if (mem_ready || w_timeout) begin
          w_next_state = c_ST_FETCH;
        end else begin
          w_next_state = c_ST_MEMWR;
        end
      end
      c_ST_EXEC:   w_next_state = w_funct_legal ? c_ST_ALUWB : c_ST_FETCH;
      c_ST_ADDIEX: w_next_state = c_ST_ADDIWB;
      default:     w_next_state = c_ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    alu_control = c_ALU_ADD;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;
    case (r_state)
      c_ST_RESET: alu_control = 4'b0000;
      c_ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        mem_err   = w_timeout;
      end
      c_ST_DECODE: begin
        pc_write   = 1'b1;
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b11;
        illegal_op = !w_op_legal;
      end
      c_ST_MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      c_ST_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        mem_err  = w_timeout;
      end
      c_ST_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      c_ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        mem_err   = w_timeout;
      end
      c_ST_EXEC: begin
        alu_src_a   = 2'b01;
        alu_control = w_funct_alu;
        illegal_op  = !w_funct_legal;
      end
      c_ST_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      // ALUOut still holds the target computed in DECODE, so pc_source stays 00.
      c_ST_BRANCH: begin
        alu_src_a   = 2'b01;
        alu_control = c_ALU_SUB;
        pc_write    = zero;
      end
      c_ST_ADDIEX: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      c_ST_ADDIWB: reg_write = 1'b1;
      c_ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Bench for multicycle_control: instruction-level reference sequencer plus literal pins.
module tb_multicycle_control;

  localparam int WMAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op, mem_err;
  logic [1:0] alu_src_a, alu_src_b, pc_source;
  logic [3:0] alu_control, state;

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_valid = 1'b0;
  logic [23:0] exp_vec   = '0;
  logic [23:0] act_vec;

  always #5 clk = ~clk;

  multicycle_control #(.ENABLE_ADDI(1'b1), .MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_control(alu_control),
    .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  assign act_vec = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, pc_source, alu_control,
                    illegal_op, mem_err, state};

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // {legal, alu code} for an R-type funct field
  function automatic logic [4:0] fdec(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b100111: return 5'b1_1100;
      6'b101010: return 5'b1_0111;
      default:   return 5'b0_0010;
    endcase
  endfunction

  function automatic logic [23:0] exp_out(input int st, input logic rdy, input logic zr,
                                          input logic [5:0] op, input logic [5:0] fn,
                                          input logic tmo);
    logic pcw, io, mr, mw, irw, rd, m2r, rw, ill, me;
    logic [1:0] sa, sb, ps;
    logic [3:0] alu;
    logic [4:0] fd;
    {pcw, io, mr, mw, irw, rd, m2r, rw, ill, me} = '0;
    sa = 2'b00; sb = 2'b00; ps = 2'b00; alu = 4'b0010;
    fd = fdec(fn);
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; me = tmo; end
      1:  begin pcw = 1; sa = 2'b10; sb = 2'b11; ill = !legal_op(op); end
      2:  begin sa = 2'b01; sb = 2'b10; end
      3:  begin io = 1; mr = 1; me = tmo; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; me = tmo; end
      6:  begin sa = 2'b01; alu = fd[3:0]; ill = !fd[4]; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 2'b01; alu = 4'b0110; pcw = zr; end
      9:  begin sa = 2'b01; sb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, io, mr, mw, irw, rd, m2r, rw, sa, sb, ps, alu, ill, me, 4'(st)};
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      n_tests++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t op=%b fn=%b actual=%h required=%h",
                 $time, opcode, funct, act_vec, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of the reference: entered and left at posedge+1.
  task automatic cycle(input int st, input logic rdy, input logic tmo, input int zsel);
    logic zr;
    zr = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
    mem_ready = rdy;
    zero      = zr;
    exp_vec   = exp_out(st, rdy, zr, opcode, funct, tmo);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cycle(input int st, input int zsel);
    cycle(st, 1'($urandom_range(0, 1)), 1'b0, zsel);
  endtask

  // Memory access that sees nw not-ready cycles before ready; ok=0 on timeout.
  task automatic mem_phase(input int st, input int nw, output logic ok);
    ok = 1'b0;
    for (int k = 0; k <= nw; k++) begin
      if (k >= nw) begin
        cycle(st, 1'b1, 1'b0, -1);
        ok = 1'b1;
        return;
      end else if (WMAX > 0 && k == WMAX) begin
        cycle(st, 1'b0, 1'b1, -1);
        return;
      end else begin
        cycle(st, 1'b0, 1'b0, -1);
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel,
                           input int wf, input int wm);
    logic ok;
    opcode = op;
    funct  = fn;
    mem_phase(0, wf, ok);
    if (!ok) return;
    rnd_cycle(1, -1);
    if (!legal_op(op)) return;
    case (op)
      6'b000000: begin
        rnd_cycle(6, -1);
        if (fdec(fn) >= 5'b1_0000) rnd_cycle(7, -1);
      end
      6'b100011: begin
        rnd_cycle(2, -1);
        mem_phase(3, wm, ok);
        if (ok) rnd_cycle(4, -1);
      end
      6'b101011: begin
        rnd_cycle(2, -1);
        mem_phase(5, wm, ok);
      end
      6'b000100: rnd_cycle(8, zsel);
      6'b000010: rnd_cycle(11, -1);
      default: begin
        rnd_cycle(9, -1);
        rnd_cycle(10, -1);
      end
    endcase
  endtask

  // Asserts reset wherever the bench is, releases it on the next negedge and
  // returns at posedge+1 with the DUT in FETCH.
  task automatic do_reset();
    exp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd15);
    chk("reset_outs", 32'(act_vec), 32'h00000F);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_hold", 32'(state), 32'd15);
    @(posedge clk);
    #1;
    chk("post_reset_fetch", 32'(state), 32'd0);
    chk("post_reset_mem_read", 32'(mem_read), 32'd1);
    chk("post_reset_alu", 32'(alu_control), 32'b0010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    int k;
    logic [5:0] op, fn;
    logic [5:0] legal_fn[6];
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    seq = '{0, 1, 6, 7, 0};
    rst_n = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset();

    // NOR R-type with hand-computed literals
    opcode = 6'b000000; funct = 6'b100111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("nor_state", 32'(state), 32'(seq[i]));
      if (i == 2) chk("nor_exec_alu", 32'(alu_control), 32'b1100);
      if (i == 3) chk("nor_wb", 32'({reg_write, reg_dst, mem_to_reg}), 32'b110);
      if (i < 4) begin @(posedge clk); #1; end
    end

    run_instr(6'b100011, 6'd0, -1, 0, 3);          // lw with 3 waits in MEMRD
    run_instr(6'b000100, 6'd0, 1, 0, 0);           // beq taken
    run_instr(6'b000100, 6'd0, 0, 1, 0);           // beq not taken
    run_instr(6'b111111, 6'd0, -1, 0, 0);          // illegal opcode
    run_instr(6'b000000, 6'b000001, -1, 0, 0);     // illegal funct
    run_instr(6'b101011, 6'd0, -1, 0, 100);        // sw with memory stuck: timeout
    run_instr(6'b001000, 6'd0, -1, 2, 0);          // addi
    run_instr(6'b000010, 6'd0, -1, 0, 0);          // j
    run_instr(6'b100011, 6'd0, -1, 7, 0);          // fetch timeout

    // reset asserted mid-EXEC
    exp_valid = 1'b0;
    opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    for (int i = 0; i < 8 && state != 4'd6; i++) begin @(posedge clk); #1; end
    chk("reach_exec", 32'(state), 32'd6);
    #2;
    do_reset();

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 7);
      fn = legal_fn[$urandom_range(0, 5)];
      case (k)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        6: begin
          op = 6'($urandom);
          while (legal_op(op)) op = 6'($urandom);
        end
        default: begin op = 6'b000000; fn = 6'($urandom); end
      endcase
      run_instr(op, fn, -1,
                ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 2)),
                int'($urandom_range(0, 6)));
    end

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control unit. It sits directly upstream of the 32-bit ALU, whose output register serves as ALUOut.
- Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK.
- Drives datapath mux selects, memory and register-file enables, and the ALU's 4-bit control code.
- Consumes the ALU's combinational zero flag to resolve beq.

Parameters:
- ENABLE_ADDI, 1: 1 decodes addi (opcode 001000); 0 treats it as illegal.
- MEM_WAIT_MAX, 0: maximum mem_ready wait cycles per memory state; 0 means unbounded.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26], from the IR
- funct  in  6  instr[5:0], from the IR
- zero  in  1  ALU equality flag (in1==in2), combinational
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 = PC, 01 = regA, 10 = ALUOut
- alu_src_b  out  2  00 = regB, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2
- pc_source  out  2  00 = ALUOut, 10 = {PC[31:28], addr26, 2'b00}
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 MIN, 1100 NOR
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- mem_err  out  1  one-cycle pulse on a memory wait timeout
- state  out  4  current state, for debug

Behaviour:
- Reset: rst_n low forces state RESET (15) asynchronously. In RESET all outputs are 0 and state=15. The next clk moves to FETCH. Reset mid-instruction abandons the instruction; no write occurs after reset assertion.
- Output timing: Moore decode from state. mem_ready gates only the enables listed. Unlisted outputs are 0 in each state, except alu_control=0010 (ADD) by default.
- FETCH(0): iord=0, mem_read=1, src_a=00, src_b=01, ADD. ir_write and pc_write are 0 while mem_ready=0. On mem_ready=1: ir_write=1, go to DECODE. ALUOut captures PC+4.
- DECODE(1): pc_write=1, pc_source=00 (PC<=PC+4), src_a=10, src_b=11, ADD; ALUOut becomes the branch target. Opcode dispatch:
  - 000000 -> EXEC(6)
  - 100011 or 101011 -> MEMADR(2)
  - 000100 -> BRANCH(8)
  - 000010 -> JUMP(11)
  - 001000 -> ADDIEX(9) when ENABLE_ADDI=1
  - anything else: illegal_op=1, go to FETCH
- MEMADR(2): src_a=01, src_b=10, ADD. lw -> MEMRD(3); sw -> MEMWR(5).
- MEMRD(3): iord=1, mem_read=1. Hold until mem_ready=1, then go to MEMWB(4).
- MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR(5): iord=1, mem_write=1. Hold until mem_ready=1, then FETCH.
- EXEC(6): src_a=01, src_b=00. funct mapping: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 MIN(0111). On an unknown funct: illegal_op=1, go to FETCH, no writeback. Otherwise go to ALUWB(7).
- ALUWB(7): reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BRANCH(8): src_a=01, src_b=00, SUB, pc_source=00. pc_write=zero, so the target still held in ALUOut is loaded. Then FETCH.
- ADDIEX(9): src_a=01, src_b=10, ADD, then ADDIWB(10).
- ADDIWB(10): reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JUMP(11): pc_write=1, pc_source=10, then FETCH.
- States 12-14 are unreachable; if entered, go to FETCH.
- Wait counter: an internal counter clears on entry to FETCH, MEMRD or MEMWR and counts cycles with mem_ready=0.
  - When MEM_WAIT_MAX>0 and the count reaches MEM_WAIT_MAX: mem_err=1 for one cycle and the next state is FETCH, with no ir_write, reg_write or pc_write.
  - If mem_ready=1 on that same cycle, completion wins.
- Instruction latency with mem_ready held 1 (clk edges from FETCH to return to FETCH): R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.

Test Plan:
- Reset: rst_n low mid-EXEC -> state=15 and all outputs 0 immediately. After release: RESET then FETCH one clk later, mem_read=1, alu_control=0010.
- R-type: opcode 000000, funct 100111, mem_ready=1 -> states 0,1,6,7,0. alu_control=1100 in EXEC; reg_write=1, reg_dst=1 in ALUWB.
- lw with waits: opcode 100011, mem_ready low 3 cycles in MEMRD -> 3 extra MEMRD cycles. reg_write only in MEMWB, with mem_to_reg=1.
- beq: opcode 000100 with zero=1 -> pc_write=1, pc_source=00 in state 8. With zero=0 -> pc_write=0. Both return to FETCH.
- Illegal: opcode 111111 -> illegal_op pulses in DECODE, next state FETCH. Same for opcode 000000 with funct 000001 (pulse in EXEC, no reg_write).
- Timeout: MEM_WAIT_MAX=4, sw with mem_ready stuck 0 -> mem_err pulses after 4 MEMWR wait cycles, then FETCH; mem_write never accepted.
